// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package instruction_fetch_stage_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_e;

  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam int unsigned PC_INC       = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module if_id_reg
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                hold_i,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [31:0]         instr_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [31:0]         instr_o
);
  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         instr_q;

  // A bubble only clears valid; pc/instr keep their last contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (!hold_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID
// through a one-entry skid buffer and honours decode stall and EX redirect.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(DEF_RESET_PC),
  parameter int unsigned          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  input  logic                 id_stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 if_id_valid,
  output logic [PC_WIDTH-1:0]  if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic [CNT_WIDTH-1:0] fetch_count
);
  fetch_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d, fetch_pc_q, fetch_pc_d, skid_pc_q, skid_pc_d;
  logic [31:0]          skid_instr_q, skid_instr_d;
  logic                 squash_q, squash_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ld, accept;
  logic [PC_WIDTH-1:0]  ld_pc, redir_aligned;
  logic [31:0]          ld_instr;

  assign accept        = !id_stall || !if_id_valid;
  assign redir_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign imem_req      = !rst && (state_q == S_IDLE) && !redirect_valid;
  assign imem_addr     = rst ? '0 : pc_q;
  assign fetch_count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      squash_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      squash_q     <= squash_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    squash_d     = squash_q;
    cnt_d        = cnt_q;
    ld           = 1'b0;
    ld_pc        = fetch_pc_q;
    ld_instr     = imem_rdata;
    if (redirect_valid) begin
      pc_d = redir_aligned;
      // An in-flight request cannot be cancelled; mark its data for discard.
      if (state_q == S_WAIT && !imem_rvalid) begin
        squash_d = 1'b1;
      end else begin
        state_d  = S_IDLE;
        squash_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
        end
        S_WAIT: if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_IDLE;
          end else if (accept) begin
            ld = 1'b1;
          end else begin
            skid_pc_d    = fetch_pc_q;
            skid_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: if (accept) begin
          ld       = 1'b1;
          ld_pc    = skid_pc_q;
          ld_instr = skid_instr_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (ld) begin
      pc_d    = pc_q + PC_WIDTH'(PC_INC);
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      state_d = S_IDLE;
    end
  end

  if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .hold_i  (id_stall),
    .flush_i (redirect_valid),
    .pc_i    (ld_pc),
    .instr_i (ld_instr),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr)
  );
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized + directed bench: a memory model with variable latency feeds the DUT,
// expected IF/ID entries are queued at data return and checked by a separate monitor.
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] fetch_count;

  instruction_fetch_stage #(.PC_WIDTH(64), .RESET_PC(64'h0), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];

  int n_checks = 0, n_fail = 0;
  // memory / reference model state
  bit          outstanding = 0, out_squashed = 0;
  logic [63:0] out_addr = '0, exp_pc = '0;
  int          lat_left = 0, lat_min = 0, lat_max = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    if (a == 64'h4) return 32'h0020_8133;
    return (a[31:0] * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  // Monitor: one look per cycle, shortly after the rising edge.
  initial begin
    bit          p_stall, p_redir, p_rst, prev_valid;
    logic [63:0] prev_pc;
    logic [31:0] prev_instr, prev_count, exp_count;
    ent_t        e;
    prev_valid = 0; prev_pc = '0; prev_instr = '0; prev_count = '0; exp_count = '0;
    forever begin
      @(posedge clk);
      p_stall = id_stall; p_redir = redirect_valid; p_rst = rst;
      #2;
      if (rst || p_rst) begin
        exp_count = '0;
      end else if (fetch_count != prev_count) begin
        if (q.size() == 0) begin
          chk("unexpected_load", 1'b0, 64'(fetch_count), 64'(prev_count));
        end else begin
          e = q.pop_front();
          exp_count = exp_count + 32'd1;
          chk("load_valid", if_id_valid == 1'b1, 64'(if_id_valid), 64'h1);
          chk("load_pc", if_id_pc == e.pc, if_id_pc, e.pc);
          chk("load_instr", if_id_instr == e.instr, 64'(if_id_instr), 64'(e.instr));
          chk("fetch_count", fetch_count == exp_count, 64'(fetch_count), 64'(exp_count));
        end
      end else if (p_redir) begin
        chk("flush_valid", if_id_valid == 1'b0, 64'(if_id_valid), 64'h0);
      end else if (p_stall && prev_valid) begin
        chk("hold_valid", if_id_valid == 1'b1, 64'(if_id_valid), 64'h1);
        chk("hold_pc", if_id_pc == prev_pc, if_id_pc, prev_pc);
        chk("hold_instr", if_id_instr == prev_instr, 64'(if_id_instr), 64'(prev_instr));
      end else begin
        chk("bubble_valid", if_id_valid == 1'b0, 64'(if_id_valid), 64'h0);
      end
      prev_valid = if_id_valid; prev_pc = if_id_pc; prev_instr = if_id_instr; prev_count = fetch_count;
    end
  end

  // One cycle of stimulus: drive at the falling edge, then check the request.
  task automatic step(input bit stall, input bit redir, input logic [63:0] rpc, input bit late_rv);
    bit rv, exp_req;
    @(negedge clk);
    rst = 1'b0;
    rv  = 1'b0;
    if (outstanding) begin
      if (lat_left == 0) rv = 1'b1;
      else lat_left--;
    end
    exp_req        = !redir && !outstanding && q.size() == 0;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = rv || late_rv;
    imem_rdata     = rv ? mem_word(out_addr) : 32'hDEAD_BEEF;
    if (rv) begin
      if (!out_squashed && !redir) begin
        q.push_back('{out_addr, mem_word(out_addr)});
        exp_pc = out_addr + 64'd4;
      end
      outstanding = 0;
    end
    if (redir) begin
      q.delete();
      exp_pc = rpc & ~64'h3;
      if (outstanding) out_squashed = 1;
    end
    #1;
    chk("imem_req", imem_req == exp_req, 64'(imem_req), 64'(exp_req));
    if (imem_req && exp_req) begin
      chk("imem_addr", imem_addr == exp_pc, imem_addr, exp_pc);
      outstanding  = 1;
      out_squashed = 0;
      out_addr     = exp_pc;
      lat_left     = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1; imem_rvalid = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
      outstanding = 0; out_squashed = 0; exp_pc = '0; q.delete();
      #1;
      chk("rst_req", imem_req == 1'b0, 64'(imem_req), 64'h0);
      chk("rst_addr", imem_addr == '0, imem_addr, 64'h0);
      chk("rst_valid", if_id_valid == 1'b0, 64'(if_id_valid), 64'h0);
      chk("rst_pc", if_id_pc == '0, if_id_pc, 64'h0);
      chk("rst_instr", if_id_instr == '0, 64'(if_id_instr), 64'h0);
      chk("rst_count", fetch_count == '0, 64'(fetch_count), 64'h0);
    end
  endtask

  task automatic wait_outstanding();
    for (int i = 0; i < 10 && !outstanding; i++) step(0, 0, '0, 0);
    chk("req_issued", outstanding, 64'(outstanding), 64'h1);
  endtask

  initial begin
    logic [31:0] cnt_save;
    do_reset(2);
    // 1-cycle memory: two fetches back to back
    lat_min = 0; lat_max = 0;
    repeat (5) step(0, 0, '0, 0);
    chk("basic_count", fetch_count == 32'd2, 64'(fetch_count), 64'd2);
    chk("basic_pc", if_id_pc == 64'h4, if_id_pc, 64'h4);
    chk("basic_instr", if_id_instr == 32'h0020_8133, 64'(if_id_instr), 64'h0020_8133);
    // decode stall while the next word returns
    repeat (3) step(1, 0, '0, 0);
    repeat (4) step(0, 0, '0, 0);
    // redirect during WAIT, data returns later and is discarded
    lat_min = 2; lat_max = 2;
    wait_outstanding();
    cnt_save = fetch_count;
    step(0, 1, 64'h100, 0);
    repeat (2) step(0, 0, '0, 0);
    chk("squash_count", fetch_count == cnt_save, 64'(fetch_count), 64'(cnt_save));
    chk("squash_valid", if_id_valid == 1'b0, 64'(if_id_valid), 64'h0);
    repeat (6) step(0, 0, '0, 0);
    // redirect, rvalid and stall in one cycle
    lat_min = 0; lat_max = 0;
    wait_outstanding();
    step(1, 1, 64'h200, 0);
    repeat (5) step(0, 0, '0, 0);
    // pc wrap and unaligned target
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    repeat (6) step(0, 0, '0, 0);
    step(0, 1, 64'h103, 0);
    repeat (5) step(0, 0, '0, 0);
    // reset in WAIT, late rvalid on the first cycle out of reset
    lat_min = 3; lat_max = 3;
    wait_outstanding();
    do_reset(1);
    step(0, 0, '0, 1);
    repeat (8) step(0, 0, '0, 0);
    // random traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 600; i++)
      step(($urandom % 10) < 3, ($urandom % 20) == 0, {$urandom, $urandom}, 0);
    repeat (12) step(0, 0, '0, 0);
    chk("drain_empty", q.size() == 0, 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
